// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Parametrised N-way arbiter granting one requester at a time access to a
// single shared target. The grant is registered and one-hot. Selection is
// either round-robin (rotating priority pointer) or fixed priority (lowest
// index wins). An owner keeps its grant for as long as it keeps requesting,
// except that after MAX_HOLD consecutive cycles it is forced to hand over as
// soon as another requester is waiting. All outputs come straight from
// flops.
//
// Parameters
//   N           number of requesters, 2..16
//   MAX_HOLD    max consecutive grant cycles while someone else waits,
//               0 = the owner may hold forever
//   FIXED_PRIO  0 = round-robin, 1 = fixed priority (lower index wins)
//   IDW         width of o_gnt_id, derived from N
//
// Ports
//   i_clk        clock, everything on the rising edge
//   i_rst        synchronous reset, active high, wins over everything
//   i_req        request vector, bit i belongs to requester i
//   o_gnt        one-hot grant, all zero when nobody owns the resource
//   o_gnt_valid  OR of o_gnt
//   o_gnt_id     index of the granted requester; keeps its last value
//                while o_gnt_valid is low
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N          = 4,
  parameter int MAX_HOLD   = 8,
  parameter int FIXED_PRIO = 0,
  localparam int IDW       = $clog2(N)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_req,
  output logic [N-1:0]   o_gnt,
  output logic           o_gnt_valid,
  output logic [IDW-1:0] o_gnt_id
);

  // The hold counter needs at least one bit even when holding is unlimited.
  localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_gnt;
  logic             r_gntValid;
  logic [IDW-1:0]   r_gntId;
  logic [IDW-1:0]   r_rrPtr;
  logic [HCW-1:0]   r_holdCnt;

  logic             w_ownerReq;
  logic [N-1:0]     w_other;
  logic             w_holdFull;
  logic             w_doGrant;
  logic [IDW-1:0]   w_grantIdx;
  logic [IDW-1:0]   w_nextPtr;

  // Picks the winner out of a non-empty mask. In round-robin mode the mask
  // is rotated so that the pointer position lands at bit 0, the lowest set
  // bit of the rotated vector is found, and the offset is added back to the
  // pointer modulo N. Fixed mode simply takes the lowest set bit. The caller
  // only uses the result when the mask has at least one bit set.
  function automatic logic [IDW-1:0] selIdx(input logic [N-1:0] mask,
                                            input logic [IDW-1:0] ptr);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    int             s;
    logic [IDW-1:0] res;
    res = '0;
    if (FIXED_PRIO != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (mask[i]) begin
          res = IDW'(i);
        end
      end
    end else begin
      dbl = {mask, mask} >> ptr;
      rot = dbl[N-1:0];
      off = 0;
      for (int j = N - 1; j >= 0; j--) begin
        if (rot[j]) begin
          off = j;
        end
      end
      s = int'(ptr) + off;
      if (s >= N) begin
        s = s - N;
      end
      res = IDW'(s);
    end
    return res;
  endfunction

  // Decide whether this edge hands out a new grant and to whom. A new grant
  // happens from IDLE whenever anyone requests, and from OWNED when the
  // owner either lets go or has used up its hold budget, provided someone
  // else is asking. The owner's own bit is masked out of the candidates in
  // OWNED so a preempted owner cannot win again on the same edge.
  always_comb begin
    w_ownerReq = i_req[r_gntId];
    w_other    = i_req & ~(N'(1) << r_gntId);
    w_holdFull = (MAX_HOLD != 0) && (r_holdCnt == HCW'(MAX_HOLD));
    w_doGrant  = 1'b0;
    w_grantIdx = '0;
    if (r_state == IDLE) begin
      if (|i_req) begin
        w_doGrant  = 1'b1;
        w_grantIdx = selIdx(i_req, r_rrPtr);
      end
    end else begin
      if ((!w_ownerReq || w_holdFull) && (|w_other)) begin
        w_doGrant  = 1'b1;
        w_grantIdx = selIdx(w_other, r_rrPtr);
      end
    end
    if (w_grantIdx == IDW'(N - 1)) begin
      w_nextPtr = '0;
    end else begin
      w_nextPtr = w_grantIdx + IDW'(1);
    end
  end

  // Arbitration state machine. Every new grant restarts the hold counter at
  // one and, in round-robin mode, moves the pointer just past the winner so
  // the winner becomes lowest priority next time. An owner that keeps
  // requesting with nobody else waiting keeps its grant and the counter
  // saturates at MAX_HOLD, so preemption fires on the first edge another
  // request shows up. When the owner lets go and nobody else asks, the grant
  // drops to zero but the id register keeps pointing at the last owner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gntValid <= 1'b0;
      r_gntId    <= '0;
      r_rrPtr    <= '0;
      r_holdCnt  <= '0;
    end else if (w_doGrant) begin
      r_state    <= OWNED;
      r_gnt      <= N'(1) << w_grantIdx;
      r_gntValid <= 1'b1;
      r_gntId    <= w_grantIdx;
      r_holdCnt  <= (MAX_HOLD == 0) ? HCW'(0) : HCW'(1);
      if (FIXED_PRIO == 0) begin
        r_rrPtr <= w_nextPtr;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        OWNED: begin
          if (!w_ownerReq) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gntValid <= 1'b0;
          end else if ((MAX_HOLD != 0) && !w_holdFull) begin
            r_holdCnt <= r_holdCnt + HCW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gntValid;
  assign o_gnt_id    = r_gntId;

  // Structural guarantees of the grant outputs.
  gntOneHot: assert property (@(posedge i_clk) disable iff (i_rst)
                              $onehot0(r_gnt));
  gntValidMatches: assert property (@(posedge i_clk) disable iff (i_rst)
                                    r_gntValid == (|r_gnt));

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
//
// Three arbiters share one request/reset stimulus:
//   dut 0: N=4, MAX_HOLD=1, round-robin
//   dut 1: N=4, MAX_HOLD=4, round-robin
//   dut 2: N=4, MAX_HOLD=0, fixed priority
// A behavioural model per instance tracks owner, pointer and hold count as
// plain integers and is compared against every instance on every falling
// edge. Directed sequences add literal expectations for the interesting
// scenarios, then a long random run follows.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

  localparam int N  = 4;
  localparam int ND = 3;

  bit          clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  gnt [ND];
  logic        gv  [ND];
  logic [1:0]  gid [ND];

  int          checks   = 0;
  int          failures = 0;
  bit          cmpEn    = 1'b0;

  int          mOwner [ND];
  int          mId    [ND];
  int          mPtr   [ND];
  int          mHold  [ND];

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  rr_arbiter #(.N(4), .MAX_HOLD(1), .FIXED_PRIO(0)) dutA (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .o_gnt(gnt[0]), .o_gnt_valid(gv[0]), .o_gnt_id(gid[0]));

  rr_arbiter #(.N(4), .MAX_HOLD(4), .FIXED_PRIO(0)) dutB (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .o_gnt(gnt[1]), .o_gnt_valid(gv[1]), .o_gnt_id(gid[1]));

  rr_arbiter #(.N(4), .MAX_HOLD(0), .FIXED_PRIO(1)) dutC (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .o_gnt(gnt[2]), .o_gnt_valid(gv[2]), .o_gnt_id(gid[2]));

  function automatic int maxHoldOf(input int d);
    if (d == 0) return 1;
    if (d == 1) return 4;
    return 0;
  endfunction

  function automatic bit fixedOf(input int d);
    return (d == 2);
  endfunction

  // Winner among the set bits of mask: scan priority order starting at ptr
  // (round-robin) or at index 0 (fixed).
  function automatic int pick(input logic [3:0] mask, input int ptr, input bit fixedMode);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = fixedMode ? k : (ptr + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelGrant(input int d, input int k);
    mOwner[d] = k;
    mId[d]    = k;
    mHold[d]  = 1;
    if (!fixedOf(d)) mPtr[d] = (k + 1) % N;
  endtask

  // One clock edge worth of arbitration rules for instance d.
  task automatic modelStep(input int d);
    logic [3:0] other;
    if (rst) begin
      mOwner[d] = -1;
      mId[d]    = 0;
      mPtr[d]   = 0;
      mHold[d]  = 0;
    end else if (mOwner[d] < 0) begin
      if (req != 4'b0000) modelGrant(d, pick(req, mPtr[d], fixedOf(d)));
    end else begin
      other = req;
      other[mOwner[d]] = 1'b0;
      if (!req[mOwner[d]]) begin
        if (other != 4'b0000) modelGrant(d, pick(other, mPtr[d], fixedOf(d)));
        else mOwner[d] = -1;
      end else if (maxHoldOf(d) != 0 && mHold[d] == maxHoldOf(d) && other != 4'b0000) begin
        modelGrant(d, pick(other, mPtr[d], fixedOf(d)));
      end else if (mHold[d] < maxHoldOf(d)) begin
        mHold[d] = mHold[d] + 1;
      end
    end
  endtask

  // Advance the models on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) modelStep(d);
    if (rst) cmpEn = 1'b1;
  end

  // Compare every instance against its model on each falling edge, and
  // check that at most one grant bit is ever set.
  always @(negedge clk) begin
    logic [3:0] eg;
    if (cmpEn) begin
      for (int d = 0; d < ND; d++) begin
        eg = (mOwner[d] >= 0) ? (4'b0001 << mOwner[d]) : 4'b0000;
        checks++;
        if (gnt[d] !== eg || gv[d] !== (mOwner[d] >= 0) || gid[d] !== 2'(mId[d])) begin
          failures++;
          $display("[TB] FAIL model dut%0d t=%0t gnt=%b want %b valid=%b want %b id=%0d want %0d",
                   d, $time, gnt[d], eg, gv[d], (mOwner[d] >= 0), gid[d], mId[d]);
        end
        checks++;
        if ($countones(gnt[d]) > 1) begin
          failures++;
          $display("[TB] FAIL onehot dut%0d t=%0t gnt=%b want at most one bit", d, $time, gnt[d]);
        end
      end
    end
  end

  // Drive inputs for the next rising edge, then return on the following
  // falling edge so outputs reflect that edge.
  task automatic applyStimulus(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int d, input logic [3:0] eg,
                             input logic ev, input logic [1:0] ei);
    checks++;
    if (gnt[d] !== eg || gv[d] !== ev || gid[d] !== ei) begin
      failures++;
      $display("[TB] FAIL %s dut%0d gnt=%b want %b valid=%b want %b id=%0d want %0d",
               name, d, gnt[d], eg, gv[d], ev, gid[d], ei);
    end
  endtask

  initial begin
    logic [3:0] rotExp [4];
    logic [3:0] r;
    logic       rs;
    rotExp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b0000;
    rst = 1'b1;

    // Reset held two cycles with everyone requesting.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b1111, 1'b1);
      for (int d = 0; d < ND; d++) checkOutput("reset", d, 4'b0000, 1'b0, 2'd0);
    end
    applyStimulus(4'b1111, 1'b0);
    for (int d = 0; d < ND; d++) checkOutput("firstGrant", d, 4'b0001, 1'b1, 2'd0);

    // Round-robin rotation with MAX_HOLD=1; fixed instance keeps index 0.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b1111, 1'b0);
      checkOutput("rotate", 0, rotExp[c], 1'b1, 2'((c + 1) % 4));
      checkOutput("fixedKeep", 2, 4'b0001, 1'b1, 2'd0);
    end

    // Hold and preempt with MAX_HOLD=4.
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("holdStart", 1, 4'b0001, 1'b1, 2'd0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0101, 1'b0);
      checkOutput("holding", 1, 4'b0001, 1'b1, 2'd0);
    end
    applyStimulus(4'b0101, 1'b0);
    checkOutput("preempt", 1, 4'b0100, 1'b1, 2'd2);

    // Release hand-over without a bubble, then release to idle.
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("own1", 1, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b1010, 1'b0);
    checkOutput("own1Keep", 1, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("handover", 1, 4'b1000, 1'b1, 2'd3);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("own1Again", 1, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("releaseIdle", 1, 4'b0000, 1'b0, 2'd1);

    // Fixed priority, unlimited hold.
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b1100, 1'b0);
    checkOutput("fixedFirst", 2, 4'b0100, 1'b1, 2'd2);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1110, 1'b0);
      checkOutput("fixedHold", 2, 4'b0100, 1'b1, 2'd2);
    end
    applyStimulus(4'b1010, 1'b0);
    checkOutput("fixedNext1", 2, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("fixedThen3", 2, 4'b1000, 1'b1, 2'd3);

    // Reset in the middle of a grant clears grant and pointer.
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("midA0", 0, 4'b0001, 1'b1, 2'd0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("midA1", 0, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("midReset", 0, 4'b0000, 1'b0, 2'd0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("ptrCleared", 0, 4'b0001, 1'b1, 2'd0);
    checkOutput("ptrClearedB", 1, 4'b0001, 1'b1, 2'd0);

    // Random requests with sticky bits and occasional resets.
    r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      end
      rs = ($urandom_range(299) == 0);
      applyStimulus(r, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-way arbiter: successor to the two-requester arbiter. It grants one of N requesters a shared resource with a registered, one-hot grant. Supports round-robin or fixed-priority selection, grant hold (lock) while the owner keeps requesting, and a bounded hold time that forces hand-over when others wait. Sits between requesting masters and a single shared target; all outputs are registered.

## Interface
- N, 4: number of requesters, 2..16.
- MAX_HOLD, 8: max consecutive grant cycles while another requester waits; 0 = unlimited hold.
- FIXED_PRIO, 0: 0 = round-robin; 1 = fixed priority, lower index wins.
- IDW, $clog2(N): width of gnt_id (derived, not overridden).

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  N  request vector, bit i = requester i
- gnt  out  N  registered one-hot grant, all-zero when idle
- gnt_valid  out  1  OR of gnt, registered
- gnt_id  out  IDW  index of granted requester; holds last value when gnt_valid=0

## Operation
- State: IDLE (no owner) / OWNED (owner = gnt_id).
- Registers: gnt, gnt_valid, gnt_id, rr_ptr (IDW bits, highest-priority index for next selection), hold_cnt (width $clog2(MAX_HOLD+1), saturating).
- Reset: gnt=0, gnt_valid=0, gnt_id=0, rr_ptr=0, hold_cnt=0, state IDLE. rst wins over all other inputs; asserted mid-grant drops gnt at that edge.
- Selection function sel(mask): round-robin: first set bit of mask scanning rr_ptr, rr_ptr+1, ..., wrapping N-1 to 0. Fixed: lowest set bit of mask.
- IDLE, req!=0: gnt <= onehot(sel(req)), hold_cnt <= 1, -> OWNED. req==0: stay IDLE.
- OWNED, req[owner]=0 (release): if other = req with owner bit cleared is nonzero, grant sel(other) at the same edge, no bubble; else gnt <= 0, -> IDLE.
- OWNED, req[owner]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD, other!=0 (preempt): grant sel(other), hold_cnt <= 1.
- OWNED, req[owner]=1, otherwise: keep grant, hold_cnt <= min(hold_cnt+1, MAX_HOLD). Counter saturates when no one else waits; preemption fires at first edge another requester appears.
- On every new grant to index k: rr_ptr <= (k+1) mod N (round-robin mode only; ignored in fixed mode).
- Exactly zero or one gnt bit set at all times.
- Requests without grant are not latched: a req bit deasserted before being granted is forgotten.

## Timing
- Grant latency: req sampled at edge e, gnt visible after edge e (one cycle from first req-high cycle), matching the original arbiter.
- Release latency: owner drops req before edge e; gnt for owner low after edge e; next owner's gnt high after the same edge.
- Max wait with all N requesting, round-robin, MAX_HOLD=M>0: (N-1)*M cycles after first visible request.
- Simultaneous new requests in IDLE: one winner per sel(); losers stay pending.
- N=2, FIXED_PRIO=1, MAX_HOLD=0: reproduces priority-to-r1 behaviour with added hold.

## Test plan
- Reset: assert rst 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0 throughout; after release, first grant gnt=4'b0001 one cycle later.
- Round-robin rotation (N=4, MAX_HOLD=1): req=4'b1111 held -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; gnt_id 0,1,2,3,0.
- Hold and preempt (MAX_HOLD=4): req0 held, req2 raised cycle 2 -> gnt=0001 for 4 cycles then 0100; gnt_id=2.
- Release hand-over: owner 1 drops req while req3 high -> next edge gnt switches 0010 to 1000, no all-zero cycle; owner drops with no others -> gnt=0, gnt_valid=0, gnt_id stays 1.
- Fixed priority (FIXED_PRIO=1, MAX_HOLD=0): req=4'b1100, then req1 raised while 2 owns -> 2 kept until release, then 1 granted before 3.
- Mid-grant reset: rst during OWNED -> gnt=0 next edge, rr_ptr=0; one-hot check (at most one gnt bit) under random req for 10k cycles.
